// File: rtl/vram_arbiter_if.sv
// Bundles the scan-out, GPU write, clear and RAM signals of the VRAM arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding logic: vga_ctrl, the GPU raster back-end and the RAM.
interface vram_arbiter_if #(
  parameter int X_WIDTH    = 7,
  parameter int Y_WIDTH    = 7,
  parameter int DATA_WIDTH = 3
);
  // Scan-out side (vga_ctrl)
  logic                        iDisplay;
  logic [X_WIDTH-1:0]          iVideoMemCol;
  logic [Y_WIDTH-1:0]          iVideoMemRow;
  logic [DATA_WIDTH-1:0]       oPixel;
  logic                        oPixelValid;
  // GPU write side
  logic                        iWrValid;
  logic                        oWrReady;
  logic [X_WIDTH-1:0]          iWrCol;
  logic [Y_WIDTH-1:0]          iWrRow;
  logic [DATA_WIDTH-1:0]       iWrData;
  // Clear engine control
  logic                        iClearReq;
  logic [DATA_WIDTH-1:0]       iClearData;
  logic                        oClearBusy;
  // Single-port RAM
  logic [X_WIDTH+Y_WIDTH-1:0]  oMemAddr;
  logic                        oMemWrEn;
  logic [DATA_WIDTH-1:0]       oMemWrData;
  logic [DATA_WIDTH-1:0]       iMemRdData;

  modport slave (
    input  iDisplay, iVideoMemCol, iVideoMemRow,
    input  iWrValid, iWrCol, iWrRow, iWrData,
    input  iClearReq, iClearData,
    input  iMemRdData,
    output oPixel, oPixelValid, oWrReady, oClearBusy,
    output oMemAddr, oMemWrEn, oMemWrData
  );

  modport master (
    output iDisplay, iVideoMemCol, iVideoMemRow,
    output iWrValid, iWrCol, iWrRow, iWrData,
    output iClearReq, iClearData,
    output iMemRdData,
    input  oPixel, oPixelValid, oWrReady, oClearBusy,
    input  oMemAddr, oMemWrEn, oMemWrData
  );
endinterface

// File: rtl/vram_arbiter.sv
// VRAM arbiter: scan-out reads own the RAM during the display window.
// GPU writes are queued in a small FIFO and retired during blanking.
// The full-screen clear engine also writes only during blanking.
module vram_arbiter #(
  parameter int X_WIDTH    = 7,
  parameter int Y_WIDTH    = 7,
  parameter int DATA_WIDTH = 3,
  parameter int H_ACTIVE   = 120,
  parameter int V_ACTIVE   = 120,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           iClock,
  input  logic           iReset,
  vram_arbiter_if.slave  bus
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ADDR_W  = X_WIDTH + Y_WIDTH;
  localparam int ENTRY_W = Y_WIDTH + X_WIDTH + DATA_WIDTH;

  localparam logic [X_WIDTH-1:0] COL_LAST  = X_WIDTH'(H_ACTIVE - 1);
  localparam logic [Y_WIDTH-1:0] ROW_LAST  = Y_WIDTH'(V_ACTIVE - 1);
  // One bit wider than the coordinates so that a limit of 2**WIDTH still fits.
  localparam logic [X_WIDTH:0]   COL_LIMIT = (X_WIDTH + 1)'(H_ACTIVE);
  localparam logic [Y_WIDTH:0]   ROW_LIMIT = (Y_WIDTH + 1)'(V_ACTIVE);
  localparam logic [PTR_W:0]     CNT_ONE   = (PTR_W + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Write FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [ENTRY_W-1:0]    fifo_q [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]        fifo_count;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop, drain_done;
  logic [ENTRY_W-1:0]    head;
  logic [Y_WIDTH-1:0]    head_row;
  logic [X_WIDTH-1:0]    head_col;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_in_range;

  // Clear engine
  logic                  clear_busy_q;
  logic [DATA_WIDTH-1:0] clear_color_q;
  logic [X_WIDTH-1:0]    col_cnt_q;
  logic [Y_WIDTH-1:0]    row_cnt_q;
  logic                  clear_accept, clear_pending, clear_wr, clear_last;

  // Scan-out pipeline
  logic                  disp_d1_q, disp_d2_q;
  logic [DATA_WIDTH-1:0] pixel_q;

  // RAM port
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_wr_en;
  logic [DATA_WIDTH-1:0] mem_wr_data;

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign head = fifo_q[rd_ptr_q[PTR_W-1:0]];
  assign {head_row, head_col, head_data} = head;
  assign head_in_range = ({1'b0, head_col} < COL_LIMIT) &&
                         ({1'b0, head_row} < ROW_LIMIT);

  assign push = bus.iWrValid && !fifo_full;
  // An out-of-range head is still popped; it only skips the RAM strobe.
  assign pop  = (state_q == ST_DRAIN) && !bus.iDisplay && !fifo_empty;
  assign drain_done = pop && !push && (fifo_count == CNT_ONE);

  assign clear_accept  = bus.iClearReq && !clear_busy_q;
  assign clear_pending = clear_busy_q && (state_q != ST_CLEAR);
  assign clear_wr      = (state_q == ST_CLEAR) && !bus.iDisplay;
  assign clear_last    = clear_wr && (col_cnt_q == COL_LAST) &&
                         (row_cnt_q == ROW_LAST);

  // FIFO storage: capture accepted GPU writes as {row, col, data}.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= {ENTRY_W{1'b0}};
      end
    end else if (push) begin
      fifo_q[wr_ptr_q[PTR_W-1:0]] <= {bus.iWrRow, bus.iWrCol, bus.iWrData};
    end
  end

  // FIFO pointers; reset discards everything still queued.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      wr_ptr_q <= {(PTR_W + 1){1'b0}};
      rd_ptr_q <= {(PTR_W + 1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + CNT_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + CNT_ONE;
      end
    end
  end

  // Clear request latch: the colour is taken only when no clear is in flight.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      clear_busy_q  <= 1'b0;
      clear_color_q <= {DATA_WIDTH{1'b0}};
    end else if (clear_accept) begin
      clear_busy_q  <= 1'b1;
      clear_color_q <= bus.iClearData;
    end else if (clear_last) begin
      clear_busy_q  <= 1'b0;
    end
  end

  // Clear walk: column inner, row outer; back to (0,0) after the last pixel.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      col_cnt_q <= {X_WIDTH{1'b0}};
      row_cnt_q <= {Y_WIDTH{1'b0}};
    end else if (clear_wr) begin
      if (col_cnt_q == COL_LAST) begin
        col_cnt_q <= {X_WIDTH{1'b0}};
        if (row_cnt_q == ROW_LAST) begin
          row_cnt_q <= {Y_WIDTH{1'b0}};
        end else begin
          row_cnt_q <= row_cnt_q + Y_WIDTH'(1);
        end
      end else begin
        col_cnt_q <= col_cnt_q + X_WIDTH'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a pending clear wins over draining, but never splits a pop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_pending) begin
          state_d = ST_CLEAR;
        end else if (!fifo_empty) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (pop && clear_pending) begin
          state_d = ST_CLEAR;
        end else if (fifo_empty || drain_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_CLEAR: begin
        if (clear_last) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // RAM port mux: scan-out address in the display window, else one write.
  always_comb begin
    mem_addr    = {ADDR_W{1'b0}};
    mem_wr_en   = 1'b0;
    mem_wr_data = {DATA_WIDTH{1'b0}};
    if (bus.iDisplay) begin
      mem_addr = {bus.iVideoMemRow, bus.iVideoMemCol};
    end else if (clear_wr) begin
      mem_addr    = {row_cnt_q, col_cnt_q};
      mem_wr_en   = 1'b1;
      mem_wr_data = clear_color_q;
    end else if (pop && head_in_range) begin
      mem_addr    = {head_row, head_col};
      mem_wr_en   = 1'b1;
      mem_wr_data = head_data;
    end else begin
      mem_addr = {ADDR_W{1'b0}};
    end
  end

  // Scan-out pipeline: RAM data arrives one cycle after the address and is
  // registered once more, so the pixel trails iDisplay by two cycles.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      disp_d1_q <= 1'b0;
      disp_d2_q <= 1'b0;
      pixel_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      disp_d1_q <= bus.iDisplay;
      disp_d2_q <= disp_d1_q;
      pixel_q   <= disp_d1_q ? bus.iMemRdData : {DATA_WIDTH{1'b0}};
    end
  end

  assign bus.oPixel      = pixel_q;
  assign bus.oPixelValid = disp_d2_q;
  assign bus.oWrReady    = !fifo_full;
  assign bus.oClearBusy  = clear_busy_q;
  assign bus.oMemAddr    = mem_addr;
  assign bus.oMemWrEn    = mem_wr_en;
  assign bus.oMemWrData  = mem_wr_data;

endmodule
